// File: rtl/lab3_sweep_pkg.sv
// Shared types, sizes and golden function for the gate-network sweep checker.
package lab3_sweep_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  // Expected network response for one input vector, returned as {x_exp, y_exp}.
  // Bit mapping: a = vec[2], b = vec[1], c = vec[0].
  function automatic logic [1:0] golden(input logic [VEC_W-1:0] vec);
    logic a;
    logic b;
    logic c;
    a = vec[2];
    b = vec[1];
    c = vec[0];
    return {~(a ^ b), (a | b) & c};
  endfunction

endpackage

// File: rtl/lab3_sweep_golden.sv
// Combinational golden model: maps the current stimulus vector to the
// expected network outputs x and y.
module lab3_sweep_golden
  import lab3_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_x_exp,
  output logic             o_y_exp
);

  assign {o_x_exp, o_y_exp} = golden(i_vec);

endmodule

// File: rtl/lab3_sweep_checker.sv
// Stimulus-and-response checker for the 3-input gate network.
// Sweeps all eight input vectors LOOPS times, waits SETTLE_CYCLES per vector,
// then samples x/y and compares them against the golden model.
// Optional build macro: LAB3_SWEEP_FAILMASK_EN adds the fail_mask[7:0] output
// recording which vectors failed in any loop of the run.
module lab3_sweep_checker
  import lab3_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_c,
  input  logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
`ifdef LAB3_SWEEP_FAILMASK_EN
  ,
  output logic [NUM_VEC-1:0] fail_mask
`endif
);

  // Counter widths never collapse to zero bits, even for SETTLE_CYCLES=1 / LOOPS=1.
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(NUM_VEC - 1);

  sweep_state_e      r_state;
  sweep_state_e      w_state_next;
  logic [VEC_W-1:0]  r_vec;
  logic [CNT_W-1:0]  r_settle;
  logic [LOOP_W-1:0] r_loop;
  logic [ERR_W-1:0]  r_err;
  logic              r_ff_valid;
  logic [VEC_W-1:0]  r_ff_vec;

  logic w_start_ok;
  logic w_settle_end;
  logic w_last_check;
  logic w_in_check;
  logic w_fail;
  logic w_x_exp;
  logic w_y_exp;
  logic w_done;

  lab3_sweep_golden u_golden (
    .i_vec   (r_vec),
    .o_x_exp (w_x_exp),
    .o_y_exp (w_y_exp)
  );

  // start is only honoured when no sweep is running.
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_settle_end = (r_settle == SETTLE_LAST);
  assign w_last_check = (r_vec == VEC_LAST) && (r_loop == LOOP_LAST);
  assign w_in_check   = (r_state == CHECK);
  // Either output mismatching makes one failing check, never two.
  assign w_fail       = w_in_check && ((dut_x != w_x_exp) || (dut_y != w_y_exp));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: SETTLE for SETTLE_CYCLES cycles, then one CHECK cycle per vector.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_start_ok) begin
          w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (w_settle_end) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        w_state_next = w_last_check ? DONE : SETTLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Vector, settle and loop counters; vec feeds the stimulus outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_loop   <= '0;
    end else if (w_start_ok) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_loop   <= '0;
    end else if (r_state == SETTLE) begin
      r_settle <= w_settle_end ? '0 : r_settle + 1'b1;
    end else if (w_in_check && !w_last_check) begin
      // vec wraps 7 -> 0 naturally; the wrap advances the loop counter.
      r_vec <= r_vec + 1'b1;
      if (r_vec == VEC_LAST) begin
        r_loop <= r_loop + 1'b1;
      end
    end
  end

  // Saturating error counter and first-failure capture, cleared by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (w_start_ok) begin
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (w_fail) begin
      if (r_err != {ERR_W{1'b1}}) begin
        r_err <= r_err + 1'b1;
      end
      if (!r_ff_valid) begin
        r_ff_valid <= 1'b1;
        r_ff_vec   <= r_vec;
      end
    end
  end

`ifdef LAB3_SWEEP_FAILMASK_EN
  logic [NUM_VEC-1:0] r_mask;

  // Per-vector sticky failure flags across all loops of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (w_start_ok) begin
      r_mask <= '0;
    end else if (w_fail) begin
      r_mask[r_vec] <= 1'b1;
    end
  end

  assign fail_mask = r_mask;
`else
  // Without the fail mask only the aggregate count and first failure are reported.
`endif

  assign stim_a           = r_vec[2];
  assign stim_b           = r_vec[1];
  assign stim_c           = r_vec[0];
  assign busy             = (r_state == SETTLE) || (r_state == CHECK);
  assign w_done           = (r_state == DONE);
  assign done             = w_done;
  assign pass             = w_done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule
